// File: rtl/control_param_encoder.sv
// Reply-word encoder for the host control-parameter link: serialises decoder status
// pulses and PI parameter readback (single read or full-table dump) into 32-bit words.
module control_param_encoder #(
    parameter int signalBitSize = 16,
    parameter int coeffBitSize  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     status_ack,
    input  logic                     status_nak,
    input  logic                     status_err,
    input  logic [7:0]               status_addr,
    input  logic                     read_req,
    input  logic [7:0]               read_addr,
    input  logic                     dump_req,
    input  logic [coeffBitSize-1:0]  pi_kp_coefficient,
    input  logic [coeffBitSize-1:0]  pi_ti_coefficient,
    input  logic [coeffBitSize-1:0]  pi_setpoint,
    input  logic [signalBitSize-1:0] pi_limit_HI,
    input  logic [signalBitSize-1:0] pi_limit_LO,
    output logic [31:0]              tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     status_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_r;
    logic        slot_full_r;
    logic [7:0]  slot_addr_r;
    logic [7:0]  slot_tag_r;
    logic        is_dump_r;
    logic        is_status_r;
    logic [2:0]  idx_r;
    logic [7:0]  addr_r;

    logic        status_any_s;
    logic [7:0]  status_tag_s;
    logic [7:0]  word_addr_s;
    logic [31:0] data_word_s;

    // Dump order follows the decoder's address map, skipping the unused 06.
    function automatic logic [7:0] dump_addr(input logic [2:0] idx);
        logic [7:0] a;
        case (idx)
            3'd0:    a = 8'h01;
            3'd1:    a = 8'h02;
            3'd2:    a = 8'h03;
            3'd3:    a = 8'h04;
            3'd4:    a = 8'h05;
            3'd5:    a = 8'h07;
            3'd6:    a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Resolve simultaneous status pulses: err beats nak beats ack.
    always_comb begin
        status_any_s = status_err | status_nak | status_ack;
        if (status_err) begin
            status_tag_s = 8'hEE;
        end else if (status_nak) begin
            status_tag_s = 8'h5A;
        end else if (status_ack) begin
            status_tag_s = 8'hA5;
        end else begin
            status_tag_s = 8'h00;
        end
    end

    // Build the readback word from live parameter values at load time.
    always_comb begin
        if (is_dump_r) begin
            word_addr_s = dump_addr(idx_r);
        end else begin
            word_addr_s = addr_r;
        end
        case (word_addr_s)
            8'h01:   data_word_s = {word_addr_s, 8'h00, 16'(pi_kp_coefficient >> 5'd16)};
            8'h02:   data_word_s = {word_addr_s, 8'h00, pi_kp_coefficient[15:0]};
            8'h03:   data_word_s = {word_addr_s, 8'h00, 16'(pi_ti_coefficient >> 5'd16)};
            8'h04:   data_word_s = {word_addr_s, 8'h00, pi_ti_coefficient[15:0]};
            8'h05:   data_word_s = {word_addr_s, 8'h00, 16'(pi_setpoint[signalBitSize-1:0])};
            8'h07:   data_word_s = {word_addr_s, 8'h00, 16'(pi_limit_HI)};
            8'h08:   data_word_s = {word_addr_s, 8'h00, 16'(pi_limit_LO)};
            default: data_word_s = {word_addr_s, 8'hFF, 16'h0000};
        endcase
    end

    // Reply FSM plus the one-deep status slot; slot take and capture are mutually exclusive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            tx_data         <= 32'h0000_0000;
            tx_valid        <= 1'b0;
            busy            <= 1'b0;
            status_overflow <= 1'b0;
            slot_full_r     <= 1'b0;
            slot_addr_r     <= 8'h00;
            slot_tag_r      <= 8'h00;
            is_dump_r       <= 1'b0;
            is_status_r     <= 1'b0;
            idx_r           <= 3'd0;
            addr_r          <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_valid <= 1'b0;
                    if (slot_full_r) begin
                        tx_data     <= {slot_addr_r, slot_tag_r, 16'h0000};
                        tx_valid    <= 1'b1;
                        is_status_r <= 1'b1;
                        slot_full_r <= 1'b0;
                        state_r     <= SEND;
                    end else if (busy) begin
                        state_r <= LOAD;
                    end else if (read_req) begin
                        addr_r    <= read_addr;
                        is_dump_r <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= LOAD;
                    end else if (dump_req) begin
                        idx_r     <= 3'd0;
                        is_dump_r <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    tx_data     <= data_word_s;
                    tx_valid    <= 1'b1;
                    is_status_r <= 1'b0;
                    state_r     <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (is_status_r) begin
                            state_r <= busy ? LOAD : IDLE;
                        end else if (is_dump_r && (idx_r != 3'd6)) begin
                            // Detour through IDLE so a waiting status word goes out between dump words.
                            idx_r   <= idx_r + 3'd1;
                            state_r <= slot_full_r ? IDLE : LOAD;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase

            if (status_any_s) begin
                if (slot_full_r) begin
                    status_overflow <= 1'b1;
                end else begin
                    slot_full_r <= 1'b1;
                    slot_addr_r <= status_addr;
                    slot_tag_r  <= status_tag_s;
                end
            end
        end
    end

endmodule
